lane_fifo_bank: RTL
===================

// Module: lane_fifo_bank
// PURPOSE
//  Bank of FUNNEL_WIDTH independent FIFO lanes that sits directly upstream of the
//  select-out funnel. A single steered enq port writes a word into the lane named
//  by enq$lane. Each lane exposes a first/deq FIFO interface; the funnel's in[]
//  vector connects to these interfaces, so the funnel can pick one lane and drain it.
// PARAMETERS
//  FUNNEL_WIDTH  8   number of lanes (>=2)
//  WIDTH         16  data bits per word
//  DEPTH         4   words per lane; power of 2, >=2
//  LW            $clog2(FUNNEL_WIDTH)  lane index width (localparam)
// PORTS
//  CLK              in   1                     clock, all state on posedge
//  nRST             in   1                     synchronous reset, active-low
//  enq__ENA         in   1                     enqueue strobe
//  enq$v            in   WIDTH                 word to enqueue
//  enq$lane         in   LW                    target lane index
//  enq__RDY         out  1                     target lane can accept this cycle
//  lane_deq__ENA    in   FUNNEL_WIDTH          per-lane dequeue strobe
//  lane_deq__RDY    out  FUNNEL_WIDTH          per-lane not-empty
//  lane_first       out  FUNNEL_WIDTH*WIDTH    per-lane head word; lane i at [i*WIDTH +: WIDTH]
//  lane_first__RDY  out  FUNNEL_WIDTH          per-lane not-empty (same as deq__RDY)
//  lane_nonempty    out  FUNNEL_WIDTH          status vector, same as lane_deq__RDY
// BEHAVIOUR
//  Reset (nRST==0 at posedge): every lane count, rd_ptr and wr_ptr are set to 0.
//   Storage RAM is not reset. After reset, all __RDY outputs for lanes are 0.
//   enq__RDY is 1 for any valid lane. lane_first is all-zero.
//   Reset mid-traffic discards all buffered words.
//  Per lane i: count_i in 0..DEPTH, width $clog2(DEPTH)+1.
//   rd_ptr_i and wr_ptr_i are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
//  enq__RDY is combinational: (enq$lane < FUNNEL_WIDTH) && count[enq$lane] != DEPTH.
//   It depends only on registered state and enq$lane, never on lane_deq__ENA.
//   A full lane therefore refuses enq even when it is dequeued in the same cycle.
//  Enqueue fires on enq__ENA && enq__RDY: mem[lane][wr_ptr] <= enq$v, wr_ptr++.
//   enq__ENA with enq__RDY==0 is ignored and state is unchanged.
//   An out-of-range lane index always yields RDY=0.
//  Dequeue fires on lane_deq__ENA[i] && count_i!=0: rd_ptr_i++.
//   deq__ENA on an empty lane is ignored and flagged by a simulation assertion.
//  Simultaneous fire on the same lane: count unchanged, both pointers advance.
//   Several lanes may dequeue in one cycle; only one lane enqueues per cycle.
//  count_i next value = count_i + enq_fire_i - deq_fire_i.
//  Latency: a word enqueued at edge N is visible on lane_first at edge N+1,
//   with __RDY=1. There is no same-cycle bypass.
//  lane_first[i] = mem[i][rd_ptr_i] when count_i!=0, else 0 (deterministic when empty).
//  Ordering is FIFO strictly per lane. There is no ordering between lanes.
//  There is no back-pressure coupling between lanes: a full lane blocks only itself.
// TESTING
//  1. Reset, then enq 0x1234 to lane 3. Next cycle: lane_deq__RDY=8'h08,
//     lane_first[3]=0x1234, and all other lanes read 0.
//  2. Fill lane 0 with 4 words (0xA0..0xA3) -> enq__RDY=0 for lane 0 and 1 for lane 1.
//     Deq 4 times -> data 0xA0,0xA1,0xA2,0xA3 in order, then RDY=0.
//  3. Lane 2 full, with enq and deq on lane 2 in the same cycle -> enq ignored,
//     count goes 4->3, and the head advances.
//  4. Lane 5 holds 2 words, with enq and deq on lane 5 in the same cycle -> count stays 2.
//     Drive 12 enq/deq cycles to force pointer wrap. Output order must match a reference queue.
//  5. Deq strobes on lanes 1 and 6 together, each holding 1 word -> both empty next
//     cycle, and lane_nonempty clears bits 1 and 6.
//  6. Lanes 0 and 7 partly full, drive nRST=0 for one cycle -> all lanes empty,
//     and lane_first=0. Enq after reset to lane 7 works normally.

Source files
------------

// File: rtl/lane_fifo_bank_if.sv
// lane_fifo_bank_if: steered enqueue port plus per-lane first/deq views of the FIFO bank
interface lane_fifo_bank_if #(
    parameter int FUNNEL_WIDTH = 8,
    parameter int WIDTH        = 16
);
    localparam int LW = $clog2(FUNNEL_WIDTH);
    logic                          enq_ena;
    logic [WIDTH-1:0]              enq_v;
    logic [LW-1:0]                 enq_lane;
    logic                          enq_rdy;
    logic [FUNNEL_WIDTH-1:0]       deq_ena;
    logic [FUNNEL_WIDTH-1:0]       deq_rdy;
    logic [FUNNEL_WIDTH*WIDTH-1:0] first;
    logic [FUNNEL_WIDTH-1:0]       first_rdy;
    logic [FUNNEL_WIDTH-1:0]       nonempty;
    modport master (
        output enq_ena, enq_v, enq_lane, deq_ena,
        input  enq_rdy, deq_rdy, first, first_rdy, nonempty
    );
    modport slave (
        input  enq_ena, enq_v, enq_lane, deq_ena,
        output enq_rdy, deq_rdy, first, first_rdy, nonempty
    );
endinterface

// File: rtl/lane_fifo_bank.sv
// lane_fifo_bank: bank of independent per-lane FIFOs fed by one steered enqueue port
module lane_fifo_bank #(
    parameter int FUNNEL_WIDTH = 8,
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4
) (
    input logic             CLK,
    input logic             nRST,
    lane_fifo_bank_if.slave bus
);
    localparam int LW = $clog2(FUNNEL_WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    logic [FUNNEL_WIDTH-1:0] full;
    logic [FUNNEL_WIDTH-1:0] nonempty;
    logic                    in_range;
    assign in_range      = int'(bus.enq_lane) < FUNNEL_WIDTH;
    assign bus.enq_rdy   = in_range && !full[bus.enq_lane];
    assign bus.deq_rdy   = nonempty;
    assign bus.first_rdy = nonempty;
    assign bus.nonempty  = nonempty;
    for (genvar i = 0; i < FUNNEL_WIDTH; i++) begin : g_lane
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW:0]      count;
        logic [PW-1:0]    rd_ptr;
        logic [PW-1:0]    wr_ptr;
        logic             enq_fire;
        logic             deq_fire;
        assign full[i]     = count == FULL;
        assign nonempty[i] = count != '0;
        assign enq_fire    = bus.enq_ena && bus.enq_rdy && bus.enq_lane == LW'(i);
        assign deq_fire    = bus.deq_ena[i] && nonempty[i];
        assign bus.first[i*WIDTH +: WIDTH] = nonempty[i] ? mem[rd_ptr] : '0;
        // occupancy and pointers; simultaneous enq/deq leaves count unchanged
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + (PW+1)'(enq_fire) - (PW+1)'(deq_fire);
                if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
                if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
            end
        end
        // storage is deliberately left unreset; empty lanes mask it on the output
        always_ff @(posedge CLK) begin
            if (enq_fire) mem[wr_ptr] <= bus.enq_v;
        end
        // dequeue on an empty lane is a protocol error from the funnel side
        always_ff @(posedge CLK) begin
            if (nRST) assert (!(bus.deq_ena[i] && !nonempty[i]));
        end
    end
endmodule
